// File: rtl/tdc_readout.sv
// TDC channel readout: tags each channel result with the bunch-crossing time,
// buffers it in a small FIFO, handshakes the channel (rstr / tdc_raw_lock) and
// serializes buffered hits as start/19 data/parity/stop frames.
module tdc_readout #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned DROP_W     = 8
) (
    input  logic                          clk300,
    input  logic                          reset,
    input  logic                          tdc_rdy,
    input  logic [11:0]                   tdc_out,
    input  logic [6:0]                    bc_time,
    output logic                          rstr,
    output logic                          tdc_raw_lock,
    output logic                          ser_out,
    output logic                          ser_en,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [DROP_W-1:0]             drop_cnt
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned CycW  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned WordW = 19;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [WordW-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic             rstr_q;

    state_e           state_q;
    logic [CycW-1:0]  cyc_q;
    logic [4:0]       bit_q;
    logic [WordW-1:0] shift_q;
    logic             parity_q;
    logic             ser_out_q, ser_en_q, lock_q;

    logic             bit_last, fifo_empty, fifo_full, pop, push, drop;
    logic [WordW-1:0] rd_word;

    // FIFO control: a pop on the same edge frees a slot for an incoming hit.
    always_comb begin
        bit_last   = (cyc_q == CycW'(BIT_CYCLES - 1));
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CntW'(FIFO_DEPTH));
        pop        = !fifo_empty &&
                     ((state_q == StIdle) || ((state_q == StStop) && bit_last));
        push       = tdc_rdy && (!fifo_full || pop);
        drop       = tdc_rdy && fifo_full && !pop;
        rd_word    = mem[rd_ptr_q];

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        drop_d = drop_q;
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // Hit storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk300) begin
        if (push) begin
            mem[wr_ptr_q] <= {bc_time, tdc_out};
        end
    end

    // Pointers, occupancy, drop counter and channel strobe.
    always_ff @(posedge clk300 or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            rstr_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            drop_q  <= drop_d;
            rstr_q  <= tdc_rdy;
        end
    end

    // Frame serializer; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk300 or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            ser_out_q <= 1'b0;
            ser_en_q  <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            if (state_q != StIdle) begin
                cyc_q <= bit_last ? '0 : cyc_q + CycW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q   <= StStart;
                        shift_q   <= rd_word;
                        parity_q  <= ^rd_word;
                        ser_out_q <= 1'b1;
                        ser_en_q  <= 1'b1;
                        lock_q    <= 1'b1;
                        cyc_q     <= '0;
                    end
                end
                StStart: begin
                    if (bit_last) begin
                        state_q   <= StData;
                        bit_q     <= 5'd18;
                        ser_out_q <= shift_q[WordW-1];
                    end
                end
                StData: begin
                    if (bit_last) begin
                        if (bit_q == 5'd0) begin
                            state_q   <= StParity;
                            ser_out_q <= parity_q;
                        end else begin
                            bit_q     <= bit_q - 5'd1;
                            ser_out_q <= shift_q[WordW-2];
                            shift_q   <= {shift_q[WordW-2:0], 1'b0};
                        end
                    end
                end
                StParity: begin
                    if (bit_last) begin
                        state_q   <= StStop;
                        ser_out_q <= 1'b0;
                    end
                end
                StStop: begin
                    if (bit_last) begin
                        if (pop) begin
                            state_q   <= StStart;
                            shift_q   <= rd_word;
                            parity_q  <= ^rd_word;
                            ser_out_q <= 1'b1;
                        end else begin
                            state_q   <= StIdle;
                            ser_out_q <= 1'b0;
                            ser_en_q  <= 1'b0;
                            lock_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    ser_out_q <= 1'b0;
                    ser_en_q  <= 1'b0;
                    lock_q    <= 1'b0;
                end
            endcase
        end
    end

    assign rstr         = rstr_q;
    assign tdc_raw_lock = lock_q;
    assign ser_out      = ser_out_q;
    assign ser_en       = ser_en_q;
    assign fifo_count   = count_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_tdc_readout.sv
// Bench for tdc_readout: two instances (BIT_CYCLES=1/DROP_W=8 and
// BIT_CYCLES=3/DROP_W=2). Stimulus pushes expected frames into per-instance
// queues; independent monitors decode serial frames and compare.
module tb_tdc_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rdy_a, rstr_a, lock_a, so_a, en_a;
    logic [11:0] out_a;
    logic [6:0]  bc_a;
    logic [3:0]  cnt_a;
    logic [7:0]  drop_a;

    logic        rst_b, rdy_b, rstr_b, lock_b, so_b, en_b;
    logic [11:0] out_b;
    logic [6:0]  bc_b;
    logic [3:0]  cnt_b;
    logic [1:0]  drop_b;

    tdc_readout #(.FIFO_DEPTH(8), .BIT_CYCLES(1), .DROP_W(8)) u_dut_a (
        .clk300(clk), .reset(rst_a), .tdc_rdy(rdy_a), .tdc_out(out_a), .bc_time(bc_a),
        .rstr(rstr_a), .tdc_raw_lock(lock_a), .ser_out(so_a), .ser_en(en_a),
        .fifo_count(cnt_a), .drop_cnt(drop_a)
    );

    tdc_readout #(.FIFO_DEPTH(8), .BIT_CYCLES(3), .DROP_W(2)) u_dut_b (
        .clk300(clk), .reset(rst_b), .tdc_rdy(rdy_b), .tdc_out(out_b), .bc_time(bc_b),
        .rstr(rstr_b), .tdc_raw_lock(lock_b), .ser_out(so_b), .ser_en(en_b),
        .fifo_count(cnt_b), .drop_cnt(drop_b)
    );

    int n_vec  = 0;
    int n_fail = 0;
    logic [21:0] q_a[$];
    logic [21:0] q_b[$];
    bit abort_ok_a = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        n_vec++;
        n_fail++;
        $display("FAIL %s", msg);
    endtask

    function automatic logic [21:0] frame_of(input logic [11:0] t, input logic [6:0] b);
        logic [18:0] w;
        w = {b, t};
        return {1'b1, w, ^w, 1'b0};
    endfunction

    // {ser_en, ser_out, tdc_raw_lock}
    function automatic logic [2:0] sig(input int sel);
        return (sel == 0) ? {en_a, so_a, lock_a} : {en_b, so_b, lock_b};
    endfunction

    function automatic logic [3:0] cnt_of(input int sel);
        return (sel == 0) ? cnt_a : cnt_b;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic r, input logic [11:0] t, input logic [6:0] b);
        if (sel == 0) begin
            rdy_a = r; out_a = t; bc_a = b;
        end else begin
            rdy_b = r; out_b = t; bc_b = b;
        end
    endtask

    task automatic wait_idle(input int sel, input int bound, input string name);
        int k;
        logic [2:0] s;
        k = 0;
        s = sig(sel);
        while ((s[2] || (cnt_of(sel) != 4'd0)) && (k < bound)) begin
            tick(1);
            k++;
            s = sig(sel);
        end
        chk(name, 32'(k < bound), 32'd1);
    endtask

    // Collect one frame starting at the current negedge; abort if ser_en drops.
    task automatic grab(input int sel, input int bc, output logic [21:0] f,
                        output bit aborted, output int bad);
        logic [2:0] s;
        f = '0;
        aborted = 1'b0;
        bad = 0;
        for (int i = 0; i < 22 * bc; i++) begin
            if (i > 0) @(negedge clk);
            s = sig(sel);
            if (!s[2]) begin
                aborted = 1'b1;
                return;
            end
            if (!s[0]) bad++;
            if ((i % bc) == 0) f[21 - i / bc] = s[1];
            else if (s[1] !== f[21 - i / bc]) bad++;
        end
    endtask

    initial begin : mon_a
        logic [21:0] f;
        bit ab;
        int bad;
        logic [2:0] s;
        forever begin
            @(negedge clk);
            s = sig(0);
            if (s[2]) begin
                grab(0, 1, f, ab, bad);
                if (ab) begin
                    if (!abort_ok_a) fail_now("frame_a aborted unexpectedly");
                end else if (q_a.size() == 0) begin
                    fail_now($sformatf("frame_a unexpected got 0x%0h", f));
                end else begin
                    chk("frame_a", 32'(f), 32'(q_a.pop_front()));
                    chk("frame_a_hold_lock", 32'(bad), 32'd0);
                end
            end
        end
    end

    initial begin : mon_b
        logic [21:0] f;
        bit ab;
        int bad;
        logic [2:0] s;
        forever begin
            @(negedge clk);
            s = sig(1);
            if (s[2]) begin
                grab(1, 3, f, ab, bad);
                if (ab) begin
                    fail_now("frame_b aborted unexpectedly");
                end else if (q_b.size() == 0) begin
                    fail_now($sformatf("frame_b unexpected got 0x%0h", f));
                end else begin
                    chk("frame_b", 32'(f), 32'(q_b.pop_front()));
                    chk("frame_b_hold_lock", 32'(bad), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int gaps;
        int highs;
        logic [1:0] drop_exp [5];
        drop_exp[0] = 2'd1; drop_exp[1] = 2'd2; drop_exp[2] = 2'd3;
        drop_exp[3] = 2'd3; drop_exp[4] = 2'd3;

        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b0, 12'h0, 7'h0);
        drive(1, 1'b0, 12'h0, 7'h0);
        tick(3);
        chk("rst_en", 32'({en_a, en_b}), 32'd0);
        chk("rst_lock", 32'({lock_a, lock_b}), 32'd0);
        chk("rst_so_rstr", 32'({so_a, so_b, rstr_a, rstr_b}), 32'd0);
        chk("rst_cnt_drop", 32'({cnt_a, cnt_b, drop_a, drop_b}), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick(2);

        // Single hit 0xA5C @ bc 0x15
        drive(0, 1'b1, 12'hA5C, 7'h15);
        q_a.push_back(22'b1_0010101_101001011100_1_0);
        tick(1);
        drive(0, 1'b0, 12'h0, 7'h0);
        chk("t1_rstr_E0", 32'(rstr_a), 32'd1);
        chk("t1_cnt_E0", 32'(cnt_a), 32'd1);
        chk("t1_en_E0", 32'({en_a, lock_a}), 32'd0);
        tick(1);
        chk("t1_rstr_E1", 32'(rstr_a), 32'd0);
        chk("t1_cnt_E1", 32'(cnt_a), 32'd0);
        chk("t1_start_E1", 32'({en_a, so_a, lock_a}), 32'b111);
        tick(21);
        chk("t1_stop_E22", 32'({en_a, so_a, lock_a}), 32'b101);
        tick(1);
        chk("t1_idle_E23", 32'({en_a, lock_a}), 32'd0);
        tick(3);

        // Burst of 10 from idle: 9 accepted, 1 dropped
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'b1, 12'(12'h100 + i), 7'(i + 1));
            if (i < 9) q_a.push_back(frame_of(12'(12'h100 + i), 7'(i + 1)));
            tick(1);
            chk($sformatf("t2_rstr_%0d", i), 32'(rstr_a), 32'd1);
        end
        drive(0, 1'b0, 12'h0, 7'h0);
        chk("t2_drop", 32'(drop_a), 32'd1);
        chk("t2_cnt_full", 32'(cnt_a), 32'd8);
        tick(1);
        chk("t2_rstr_end", 32'(rstr_a), 32'd0);
        gaps = 0;
        for (int e = 10; e <= 198; e++) begin
            if (!en_a) gaps++;
            tick(1);
        end
        chk("t2_en_contig", 32'(gaps), 32'd0);
        chk("t2_en_end", 32'({en_a, lock_a}), 32'd0);
        chk("t2_cnt_end", 32'(cnt_a), 32'd0);
        tick(3);

        // Write+pop on full FIFO at the STOP->START edge
        for (int i = 0; i < 9; i++) begin
            drive(0, 1'b1, 12'(12'h700 + i), 7'(7'h40 + i));
            q_a.push_back(frame_of(12'(12'h700 + i), 7'(7'h40 + i)));
            tick(1);
        end
        drive(0, 1'b0, 12'h0, 7'h0);
        tick(14);
        chk("t3_cnt_pre", 32'(cnt_a), 32'd8);
        drive(0, 1'b1, 12'h3C3, 7'h2A);
        q_a.push_back(frame_of(12'h3C3, 7'h2A));
        tick(1);
        drive(0, 1'b0, 12'h0, 7'h0);
        chk("t3_cnt_post", 32'(cnt_a), 32'd8);
        chk("t3_drop_post", 32'(drop_a), 32'd1);
        wait_idle(0, 400, "t3_drain");
        tick(3);

        // Reset during bit 10 of the first of three queued frames
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 12'(12'h0F0 + i), 7'(7'h10 + i));
            q_a.push_back(frame_of(12'(12'h0F0 + i), 7'(7'h10 + i)));
            tick(1);
        end
        drive(0, 1'b0, 12'h0, 7'h0);
        tick(8);
        chk("t5_pre_en", 32'(en_a), 32'd1);
        abort_ok_a = 1'b1;
        rst_a = 1'b1;
        q_a.delete();
        #1;
        chk("t5_rst_outs", 32'({so_a, en_a, lock_a, rstr_a}), 32'd0);
        chk("t5_rst_cnt", 32'(cnt_a), 32'd0);
        chk("t5_rst_drop", 32'(drop_a), 32'd0);
        tick(2);
        rst_a = 1'b0;
        highs = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (en_a || lock_a) highs++;
        end
        chk("t5_quiet", 32'(highs), 32'd0);
        chk("t5_quiet_cnt", 32'(cnt_a), 32'd0);
        drive(0, 1'b1, 12'h5A5, 7'h33);
        q_a.push_back(frame_of(12'h5A5, 7'h33));
        tick(1);
        drive(0, 1'b0, 12'h0, 7'h0);
        wait_idle(0, 60, "t5_after_rst");
        tick(2);
        abort_ok_a = 1'b0;

        // BIT_CYCLES=3: all-ones hit
        drive(1, 1'b1, 12'hFFF, 7'h7F);
        q_b.push_back(22'b1_1111111111111111111_1_0);
        tick(1);
        drive(1, 1'b0, 12'h0, 7'h0);
        chk("t4_rstr_E0", 32'(rstr_b), 32'd1);
        chk("t4_cnt_E0", 32'(cnt_b), 32'd1);
        tick(1);
        chk("t4_start_E1", 32'({en_b, so_b, lock_b}), 32'b111);
        chk("t4_cnt_E1", 32'(cnt_b), 32'd0);
        tick(65);
        chk("t4_stop_E66", 32'({en_b, so_b, lock_b}), 32'b101);
        tick(1);
        chk("t4_idle_E67", 32'({en_b, lock_b}), 32'd0);
        tick(3);

        // Drop saturation with DROP_W=2
        for (int i = 0; i < 14; i++) begin
            drive(1, 1'b1, 12'(12'h200 + i), 7'(i));
            if (i < 9) q_b.push_back(frame_of(12'(12'h200 + i), 7'(i)));
            tick(1);
            if (i >= 9) chk($sformatf("t6_drop_%0d", i - 9), 32'(drop_b), 32'(drop_exp[i - 9]));
        end
        drive(1, 1'b0, 12'h0, 7'h0);
        chk("t6_cnt_full", 32'(cnt_b), 32'd8);
        wait_idle(1, 1000, "t6_drain");
        tick(3);

        chk("q_a_empty", 32'(q_a.size()), 32'd0);
        chk("q_b_empty", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_readout.md
Name: tdc_readout

Overview:
- Readout end of the TDC channel interface: captures each TDCCHAN result (tdc_out on tdc_rdy), tags it with the current bc_time and buffers it in a small FIFO.
- Returns the strobe (rstr) and raw-lock (tdc_raw_lock) controls to the channel.
- Serializes buffered hits into fixed-format frames toward the downstream data link.
- Single clock domain (clk300).

Parameters:
- FIFO_DEPTH, 8, number of hit words buffered (power of two, >=2)
- BIT_CYCLES, 1, clk300 cycles each serial bit is held (>=1)
- DROP_W, 8, width of saturating dropped-hit counter

Ports:
- clk300  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- tdc_rdy  input  1  channel result valid, sampled each clk300 edge
- tdc_out  input  12  channel fine/coarse time result, valid with tdc_rdy
- bc_time  input  7  bunch-crossing time tag, sampled with tdc_rdy
- rstr  output  1  read strobe to channel: one-cycle pulse acknowledging a sampled tdc_rdy
- tdc_raw_lock  output  1  freezes channel raw register; high whenever serializer is not IDLE
- ser_out  output  1  serial frame data
- ser_en  output  1  high for every bit period of a frame (start through stop)
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- drop_cnt  output  DROP_W  hits lost to FIFO full, saturates at all-ones

Behaviour:
- Reset values:
  - rstr=0, tdc_raw_lock=0, ser_out=0, ser_en=0
  - fifo_count=0, drop_cnt=0
  - FSM=IDLE, FIFO pointers=0
- Capture:
  - Word = {bc_time, tdc_out}, 19 bits, bc_time in bits 18:12.
  - Written on the edge where tdc_rdy=1 and the FIFO is not full, counting a same-edge pop as freeing space.
  - If tdc_rdy=1 and the FIFO is full with no same-edge pop: word dropped, drop_cnt+1 (saturating).
- rstr: registered; high for the one cycle following every edge that sampled tdc_rdy=1, whether the hit was accepted or dropped. Consecutive tdc_rdy cycles give consecutive rstr cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on the edge where fifo_count>0. The pop occurs on that same edge; the word is loaded into a 19-bit shift register.
  - START: ser_out=1 for BIT_CYCLES.
  - DATA: 19 bits, MSB first, each held BIT_CYCLES; bit counter 18 down to 0.
  - PARITY: even parity over the 19 data bits (XOR of all bits), held BIT_CYCLES.
  - STOP: ser_out=0 for BIT_CYCLES. Then -> START (with pop) if fifo_count>0, else -> IDLE.
  - Frame length: 22*BIT_CYCLES cycles. Back-to-back frames have no gap beyond the stop bit.
- ser_en=1 in START/DATA/PARITY/STOP. ser_out=0 and ser_en=0 in IDLE.
- tdc_raw_lock=1 exactly while FSM != IDLE.
- Latency: tdc_rdy sampled at edge E0 with FSM idle and FIFO empty -> pop at E1 -> first start-bit cycle follows E1.
- Simultaneous write and pop: both occur; fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: frame aborted immediately, FIFO contents discarded, all outputs to reset values.

Test Plan:
- Single hit: tdc_out=0xA5C, bc_time=0x15, BIT_CYCLES=1.
  - Response: rstr one cycle after sample; start bit follows the pop edge.
  - Data bits 0010101_101001011100, parity=1 (9 ones), stop=0.
  - ser_en high 22 cycles; tdc_raw_lock high the same 22 cycles; fifo_count 1->0 at pop.
- Burst overflow: tdc_rdy high 10 consecutive edges from idle, FIFO_DEPTH=8.
  - Response: 9 words accepted (one popped at E1), drop_cnt=1, rstr high 10 cycles.
  - Nine frames follow back-to-back in write order, contiguous ser_en for 198 cycles.
- Write+pop on full FIFO: fill to 8, then assert tdc_rdy on the STOP->START edge.
  - Response: word accepted, fifo_count stays 8, drop_cnt unchanged.
- BIT_CYCLES=3: one hit with tdc_out=0xFFF, bc_time=0x7F.
  - Response: each bit held 3 cycles, frame 66 cycles, parity=1 (19 ones).
- Reset mid-DATA (bit 10 of first of 3 queued frames).
  - Response: ser_out, ser_en, tdc_raw_lock, fifo_count and drop_cnt all 0 immediately.
  - No further frames until a new tdc_rdy.
- Drop saturation: DROP_W=2, hold the FIFO full and drive 5 dropped hits.
  - Response: drop_cnt sequence 1,2,3,3,3.
